spectrum_plotter: RTL and testbench

// - VGA 640x480 FFT magnitude plotter; parametrised successor of the single-trace grapher.
// - Sits between hvsync_gen (pixel timing in) and the FFT result RAM (1-cycle read latency).
// - Draws axes, dot or bar trace of |re|+|im| per bin, optional decaying peak-hold marker, RGB out.

---
 rtl/grapher_pkg.sv | 43 ++++
 rtl/peak_hold_mem.sv | 24 ++
 rtl/spectrum_plotter.sv | 155 +++++++++++++++
 tb/tb_spectrum_plotter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/grapher_pkg.sv
// rtl/grapher_pkg.sv - shared constants and datapath helpers for the spectrum plotter
package grapher_pkg;

  localparam int MODE_BAR  = 0;
  localparam int MODE_PEAK = 1;

  localparam logic [2:0] COL_AXIS  = 3'b111;
  localparam logic [2:0] COL_PEAK  = 3'b100;
  localparam logic [2:0] COL_TRACE = 3'b010;
  localparam logic [2:0] COL_BLACK = 3'b000;

  localparam int PK_W = 9;

  // Inputs arrive sign-extended from DATA_W <= 31, so the 33-bit sum cannot overflow.
  function automatic logic [32:0] mag_l1(input logic signed [31:0] re,
                                         input logic signed [31:0] im);
    logic signed [32:0] rx, ix;
    rx = {re[31], re};
    ix = {im[31], im};
    if (rx < 0) rx = -rx;
    if (ix < 0) ix = -ix;
    return $unsigned(rx) + $unsigned(ix);
  endfunction

  function automatic logic [PK_W-1:0] scale_sat(input logic [32:0] mag,
                                                input int shift,
                                                input int lim);
    logic [32:0] s, l;
    s = mag >> shift;
    l = 33'(lim);
    return (s > l) ? l[PK_W-1:0] : s[PK_W-1:0];
  endfunction

  function automatic logic [15:0] bit_rev(input logic [15:0] v, input int w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/peak_hold_mem.sv
// rtl/peak_hold_mem.sv - per-bin peak height store, async read / sync write
module peak_hold_mem
  import grapher_pkg::*;
#(
  parameter int N_BINS = 512,
  parameter int ADDR_W = $clog2(N_BINS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PK_W-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PK_W-1:0]   rdata
);

  logic [PK_W-1:0] mem [N_BINS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spectrum_plotter.sv
// rtl/spectrum_plotter.sv - VGA FFT magnitude plotter: axes, dot/bar trace, decaying peak-hold marker
module spectrum_plotter
  import grapher_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int N_BINS       = 512,
  parameter int X_ZOOM       = 1,
  parameter int X0           = 50,
  parameter int Y0           = 100,
  parameter int GRAPH_H      = 256,
  parameter int SCALE_SHIFT  = 8,
  parameter int BITREV       = 1,
  parameter int DECAY_FRAMES = 4,
  parameter int DECAY_STEP   = 1,
  parameter int ADDR_W       = $clog2(N_BINS)
) (
  input  logic                     i_clk_24MHz,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [1:0]               i_mode,
  input  logic                     i_hs,
  input  logic                     i_vs,
  input  logic                     i_active,
  input  logic [9:0]               i_x,
  input  logic [8:0]               i_y,
  output logic                     o_rd_en,
  output logic [ADDR_W-1:0]        o_rd_addr,
  input  logic signed [DATA_W-1:0] i_rd_re,
  input  logic signed [DATA_W-1:0] i_rd_im,
  output logic                     o_hs,
  output logic                     o_vs,
  output logic                     o_r,
  output logic                     o_g,
  output logic                     o_b
);

  localparam int GRAPH_W = N_BINS * X_ZOOM;
  localparam int ZOOM_SH = $clog2(X_ZOOM);
  localparam int CNT_W   = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  localparam logic [8:0] Y_BOT = 9'(GRAPH_H - 1);

  logic              in_graph;
  logic [9:0]        xg;
  logic [8:0]        yg;
  logic [ADDR_W-1:0] bin;

  always_comb begin
    in_graph = i_active
             && ({1'b0, i_x} >= 11'(X0)) && ({1'b0, i_x} < 11'(X0 + GRAPH_W))
             && ({1'b0, i_y} >= 10'(Y0)) && ({1'b0, i_y} < 10'(Y0 + GRAPH_H));
    xg  = i_x - 10'(X0);
    yg  = i_y - 9'(Y0);
    bin = ADDR_W'(xg >> ZOOM_SH);
  end

  // RAM enable follows i_en so read data holds while the pipeline is frozen.
  assign o_rd_en   = in_graph & i_en & ~i_rst;
  assign o_rd_addr = !o_rd_en ? '0
                   : (BITREV != 0) ? ADDR_W'(bit_rev(16'(bin), ADDR_W)) : bin;

  logic              s1_in, s1_hs, s1_vs;
  logic [9:0]        s1_xg;
  logic [8:0]        s1_yg;
  logic [ADDR_W-1:0] s1_bin;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  decay_cnt;
  logic              decay_tick, clear_pending, row_started, upd_done;

  logic [32:0]     mag;
  logic [PK_W-1:0] h, top, pk, pk_disp, decayed, held, pk_new;
  logic            axis, trace, mark, pk_write, pk_we, frame_start;
  logic [2:0]      colour;

  always_comb begin
    mag      = mag_l1(32'(i_rd_re), 32'(i_rd_im));
    h        = scale_sat(mag, SCALE_SHIFT, GRAPH_H - 1);
    top      = Y_BOT - h;
    // Until a full clearing row has been written the stored peaks are stale; show them as zero.
    pk_disp  = (clear_pending && !upd_done) ? '0 : pk;
    axis     = (s1_yg == Y_BOT) || (s1_xg == '0);
    trace    = mode_q[MODE_BAR] ? (s1_yg >= top) : (s1_yg == top);
    mark     = mode_q[MODE_PEAK] && (s1_yg == (Y_BOT - pk_disp));
    colour   = COL_BLACK;
    if (s1_in) begin
      if (axis)       colour = COL_AXIS;
      else if (mark)  colour = COL_PEAK;
      else if (trace) colour = COL_TRACE;
    end
    decayed  = (pk >= 9'(DECAY_STEP)) ? pk - 9'(DECAY_STEP) : '0;
    held     = decay_tick ? decayed : pk;
    pk_new   = clear_pending ? h : ((h > held) ? h : held);
    pk_write = s1_in && (s1_yg == '0) && ((s1_xg & 10'(X_ZOOM - 1)) == '0);
    pk_we    = pk_write && i_en && !i_rst;
    frame_start = s1_vs && !i_vs;
  end

  peak_hold_mem #(
    .N_BINS (N_BINS),
    .ADDR_W (ADDR_W)
  ) u_peak (
    .clk   (i_clk_24MHz),
    .we    (pk_we),
    .waddr (s1_bin),
    .wdata (pk_new),
    .raddr (s1_bin),
    .rdata (pk)
  );

  always_ff @(posedge i_clk_24MHz) begin
    if (i_rst) begin
      s1_in         <= 1'b0;
      s1_hs         <= 1'b0;
      s1_vs         <= 1'b0;
      s1_xg         <= '0;
      s1_yg         <= '0;
      s1_bin        <= '0;
      o_hs          <= 1'b0;
      o_vs          <= 1'b0;
      {o_r, o_g, o_b} <= COL_BLACK;
      mode_q        <= '0;
      decay_cnt     <= '0;
      decay_tick    <= 1'b0;
      clear_pending <= 1'b1;
      row_started   <= 1'b0;
      upd_done      <= 1'b0;
    end else if (i_en) begin
      s1_in  <= in_graph;
      s1_hs  <= i_hs;
      s1_vs  <= i_vs;
      s1_xg  <= xg;
      s1_yg  <= yg;
      s1_bin <= bin;
      o_hs   <= s1_hs;
      o_vs   <= s1_vs;
      {o_r, o_g, o_b} <= colour;
      if (frame_start) begin
        mode_q <= i_mode;
        if (decay_cnt == CNT_W'(DECAY_FRAMES - 1)) begin
          decay_cnt  <= '0;
          decay_tick <= 1'b1;
        end else begin
          decay_cnt  <= decay_cnt + CNT_W'(1);
          decay_tick <= 1'b0;
        end
        if (upd_done) clear_pending <= 1'b0;
      end
      // A clearing row counts as complete only if it ran from bin 0 through the last bin.
      if (pk_write && clear_pending) begin
        if (s1_bin == '0) row_started <= 1'b1;
        if (row_started && s1_bin == ADDR_W'(N_BINS - 1)) upd_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spectrum_plotter.sv
// tb/tb_spectrum_plotter.sv - directed scoreboard bench for spectrum_plotter
module tb_spectrum_plotter;

  localparam int X0 = 50;
  localparam int Y0 = 100;
  localparam logic [2:0] WHT = 3'b111, RED = 3'b100, GRN = 3'b010, BLK = 3'b000;

  logic clk = 1'b0;
  always #21 clk = ~clk;

  logic               i_rst, i_en, i_hs, i_vs, i_active;
  logic [1:0]         i_mode;
  logic [9:0]         i_x;
  logic [8:0]         i_y;
  logic               o_rd_en, o_hs, o_vs, o_r, o_g, o_b;
  logic [8:0]         o_rd_addr;
  logic signed [15:0] i_rd_re, i_rd_im;

  spectrum_plotter dut (
    .i_clk_24MHz (clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_mode      (i_mode),
    .i_hs        (i_hs),
    .i_vs        (i_vs),
    .i_active    (i_active),
    .i_x         (i_x),
    .i_y         (i_y),
    .o_rd_en     (o_rd_en),
    .o_rd_addr   (o_rd_addr),
    .i_rd_re     (i_rd_re),
    .i_rd_im     (i_rd_im),
    .o_hs        (o_hs),
    .o_vs        (o_vs),
    .o_r         (o_r),
    .o_g         (o_g),
    .o_b         (o_b)
  );

  logic signed [15:0] ram_re [512];
  logic signed [15:0] ram_im [512];
  bit                 q_chk [$];
  logic [4:0]         q_exp [$];
  string              q_tag [$];
  int                 nvec = 0, nerr = 0;
  logic               prev_en;
  logic [8:0]         prev_addr;
  int                 m_cnt, m_pk, m_h9, m_old;
  bit                 m_tick, m_clear, m_upd;

  function automatic logic [8:0] rev9(input int b);
    logic [8:0] v, r;
    v = 9'(b);
    for (int i = 0; i < 9; i++) r[8-i] = v[i];
    return r;
  endfunction

  task automatic set_bin(input int b, input int re, input int im);
    ram_re[rev9(b)] = 16'(re);
    ram_im[rev9(b)] = 16'(im);
  endtask

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs seen after an edge belong to the pixel driven two steps earlier.
  task automatic step(input logic [9:0] x, input logic [8:0] y, input logic act,
                      input logic [1:0] sy, input bit chk, input logic [2:0] rgb,
                      input string tag);
    bit c;
    logic [4:0] e;
    string t;
    @(posedge clk);
    #1;
    if (q_chk.size() == 2) begin
      c = q_chk.pop_front();
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      if (c) check({27'b0, o_hs, o_vs, o_r, o_g, o_b}, {27'b0, e}, t);
    end
    if (prev_en) begin
      i_rd_re = ram_re[prev_addr];
      i_rd_im = ram_im[prev_addr];
    end
    i_x = x; i_y = y; i_active = act; i_hs = sy[1]; i_vs = sy[0];
    q_chk.push_back(chk);
    q_exp.push_back({sy, rgb});
    q_tag.push_back(tag);
    #1;
    prev_en   = o_rd_en;
    prev_addr = o_rd_addr;
  endtask

  task automatic pix(input int xg, input int yg, input logic [2:0] rgb, input string tag);
    step(10'(X0 + xg), 9'(Y0 + yg), 1'b1, 2'b11, 1'b1, rgb, tag);
  endtask

  task automatic pix_n(input int xg, input int yg);
    step(10'(X0 + xg), 9'(Y0 + yg), 1'b1, 2'b11, 1'b0, BLK, "");
  endtask

  task automatic idle();
    step(10'd0, 9'd0, 1'b0, 2'b11, 1'b1, BLK, "idle_black");
  endtask

  task automatic q_reset();
    q_chk.delete(); q_exp.delete(); q_tag.delete();
    prev_en = 1'b0;
  endtask

  task automatic fstart(input logic [1:0] mode);
    i_mode = mode;
    step(10'd0, 9'd0, 1'b0, 2'b10, 1'b1, BLK, "vsync_delay");
    step(10'd0, 9'd0, 1'b0, 2'b11, 1'b0, BLK, "");
    if (m_upd) m_clear = 1'b0;
    if (m_cnt == 3) begin m_cnt = 0; m_tick = 1'b1; end
    else begin m_cnt++; m_tick = 1'b0; end
  endtask

  task automatic model_bin9();
    int held;
    held = m_tick ? ((m_pk > 0) ? m_pk - 1 : 0) : m_pk;
    m_pk = m_clear ? m_h9 : ((m_h9 > held) ? m_h9 : held);
  endtask

  task automatic row0_full();
    for (int xg = 0; xg < 512; xg++) pix_n(xg, 0);
    model_bin9();
    if (m_clear) m_upd = 1'b1;
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b1; i_mode = 2'b00; i_hs = 1'b1; i_vs = 1'b1;
    i_active = 1'b1; i_x = 10'(X0 + 5); i_y = 9'(Y0 + 10);
    i_rd_re = '0; i_rd_im = '0;
    for (int i = 0; i < 512; i++) begin ram_re[i] = '0; ram_im[i] = '0; end
    m_cnt = 0; m_pk = 0; m_h9 = 0; m_tick = 1'b0; m_clear = 1'b1; m_upd = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check({27'b0, o_hs, o_vs, o_r, o_g, o_b}, 32'd0, "reset_outputs");
    check({31'b0, o_rd_en}, 32'd0, "reset_rd_en");
    check({23'b0, o_rd_addr}, 32'd0, "reset_rd_addr");
    i_rst = 1'b0; i_active = 1'b0;
    q_reset();

    set_bin(5, 1024, -1024);
    set_bin(7, -32768, -32768);

    idle(); idle();
    pix(5, 246, BLK, "dot_above");
    pix(5, 247, GRN, "dot_hit");
    check({23'b0, o_rd_addr}, 32'h140, "bitrev_bin5");
    pix(5, 248, BLK, "dot_below");
    pix(6, 247, BLK, "dot_next_col");
    step(10'(X0 + 5), 9'(Y0 + 247), 1'b1, 2'b01, 1'b1, GRN, "hsync_delay_green");
    pix(1, 50, BLK, "bin1_zero");
    check({23'b0, o_rd_addr}, 32'h100, "bitrev_xg1");
    check({31'b0, o_rd_en}, 32'd1, "rd_en_inside");
    pix(0, 10, WHT, "axis_left");
    pix(5, 255, WHT, "axis_bottom");
    step(10'(X0 - 1), 9'(Y0 + 247), 1'b1, 2'b11, 1'b1, BLK, "left_of_graph");
    check({31'b0, o_rd_en}, 32'd0, "rd_en_outside");
    step(10'(X0 + 5), 9'(Y0 + 256), 1'b1, 2'b11, 1'b1, BLK, "below_graph");
    pix(7, 0, GRN, "sat_dot_top");
    pix(7, 1, BLK, "sat_dot_below");
    i_mode = 2'b01;
    pix(5, 250, BLK, "mode_no_tear");

    pix_n(5, 247);
    step(10'd0, 9'd0, 1'b0, 2'b11, 1'b0, BLK, "");
    @(posedge clk);
    #1;
    check({27'b0, o_hs, o_vs, o_r, o_g, o_b}, 32'b11010, "en_before_hold");
    i_en = 1'b0; i_active = 1'b0; i_vs = 1'b0; i_hs = 1'b0; i_x = 10'd0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check({27'b0, o_hs, o_vs, o_r, o_g, o_b}, 32'b11010, "en_hold");
    end
    i_vs = 1'b1; i_hs = 1'b1; i_en = 1'b1;
    q_reset();

    fstart(2'b01);
    pix(5, 246, BLK, "bar_above");
    pix(5, 247, GRN, "bar_top");
    pix(5, 254, GRN, "bar_low");
    pix(5, 255, WHT, "bar_axis_bottom");
    pix(0, 200, WHT, "bar_axis_left");
    pix(7, 0, GRN, "sat_bar_top");
    pix(7, 128, GRN, "sat_bar_mid");
    pix(6, 254, BLK, "bar_zero_bin");
    idle();

    set_bin(9, 25600, 0);
    m_h9 = 100;
    fstart(2'b10);
    row0_full();
    pix(9, 154, BLK, "pk1_above");
    pix(9, 155, RED, "pk1_mark");
    pix(9, 156, BLK, "pk1_below");
    set_bin(9, 0, 0);
    m_h9 = 0;
    for (int f = 0; f < 8; f++) begin
      fstart(2'b10);
      pix_n(9, 0);
      model_bin9();
      pix(9, 255 - m_pk, RED, "pk_decay_mark");
      pix(9, 254 - m_pk, BLK, "pk_decay_above");
    end

    m_old = m_pk;
    pix_n(5, 247);
    pix_n(5, 247);
    @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    check({27'b0, o_hs, o_vs, o_r, o_g, o_b}, 32'd0, "midframe_reset_black");
    check({31'b0, o_rd_en}, 32'd0, "midframe_reset_rd_en");
    i_rst = 1'b0;
    q_reset();
    m_cnt = 0; m_tick = 1'b0; m_clear = 1'b1; m_upd = 1'b0;

    set_bin(9, 10240, 0);
    m_h9 = 40;
    fstart(2'b10);
    row0_full();
    pix(9, 255 - m_pk, RED, "post_reset_peak_exact");
    pix(9, 254 - m_pk, BLK, "post_reset_above");
    pix(9, 255 - m_old, BLK, "post_reset_stale_gone");
    idle(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
